// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin, message-atomic sharing of the UART TX enqueue |
// | port. UART_TX_ARB_TIMEOUT_EN adds a forced release of an idle owner.        |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module uart_tx_arbiter #(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid_i,
   input  logic [N_REQ*8-1:0] req_data_i,
   input  logic [N_REQ-1:0]   req_last_i,
   output logic [N_REQ-1:0]   req_ready_o,
   input  logic               tx_enable_i,
   input  logic               flush_i,
   output logic [7:0]         tx_d_o,
   output logic               tx_d_valid_o,
   input  logic               tx_d_ready_i,
   output logic [N_REQ-1:0]   grant_o,
   output logic               busy_o,
   output logic               timeout_o
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t            state_q;
   logic [N_REQ-1:0]  grant_q;
   logic [IW-1:0]     owner_q;
   logic [IW-1:0]     last_grant_q;

   logic [7:0]        req_byte [N_REQ];

   generate
      for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
         assign req_byte[i] = req_data_i[8*i +: 8];
      end
   endgenerate

   // Round-robin search starting one past the previous owner, wrapping at N_REQ.
   logic          arb_found;
   logic [IW-1:0] arb_idx;
   logic [IW:0]   cand;

   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = {1'b0, last_grant_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(N_REQ)) begin
            cand = cand - (IW+1)'(N_REQ);
         end
         if (!arb_found && req_valid_i[cand[IW-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = cand[IW-1:0];
         end
      end
   end

   logic pass_en;
   logic owner_valid;
   logic hs_last;

   assign pass_en      = (state_q == STREAM) && !flush_i && rst_n;
   assign owner_valid  = req_valid_i[owner_q];
   assign tx_d_valid_o = pass_en && owner_valid;
   assign tx_d_o       = tx_d_valid_o ? req_byte[owner_q] : 8'h00;
   assign req_ready_o  = pass_en ? (grant_q & {N_REQ{tx_d_ready_i}}) : '0;
   assign hs_last      = tx_d_valid_o && tx_d_ready_i && req_last_i[owner_q];

   assign grant_o = grant_q;
   assign busy_o  = (state_q == STREAM);

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] idle_cnt_q;
   logic [CW-1:0] idle_cnt_d;
   logic          timeout_q;
   logic          idle_expire;

   assign idle_cnt_d  = idle_cnt_q + CW'(1);
   assign idle_expire = (state_q == STREAM) && !owner_valid && (idle_cnt_d == CW'(TIMEOUT_CYC));
   assign timeout_o   = timeout_q;
`else
   assign timeout_o   = 1'b0 & (TIMEOUT_CYC == 0);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         owner_q      <= '0;
         last_grant_q <= IW'(N_REQ - 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
         idle_cnt_q   <= '0;
         timeout_q    <= 1'b0;
`endif
      end else if (flush_i) begin
         state_q <= IDLE;
         grant_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (tx_enable_i && arb_found) begin
                  state_q <= STREAM;
                  owner_q <= arb_idx;
                  grant_q <= N_REQ'(1) << arb_idx;
`ifdef UART_TX_ARB_TIMEOUT_EN
                  idle_cnt_q <= '0;
`endif
               end
            end
            STREAM: begin
               if (hs_last) begin
                  state_q      <= IDLE;
                  grant_q      <= '0;
                  last_grant_q <= owner_q;
               end
`ifdef UART_TX_ARB_TIMEOUT_EN
               else if (idle_expire) begin
                  state_q      <= IDLE;
                  grant_q      <= '0;
                  last_grant_q <= owner_q;
                  timeout_q    <= 1'b1;
               end
               // A stalled-but-valid owner is not idle, so only missing valid advances the count.
               if (owner_valid) begin
                  idle_cnt_q <= '0;
               end else if (!idle_expire) begin
                  idle_cnt_q <= idle_cnt_d;
               end
`endif
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// tb_uart_tx_arbiter : arbitration vector table plus scoreboarded message sequences.
module tb_uart_tx_arbiter;

   localparam int N = 4;
`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 256;
`endif

   logic           clk          = 1'b0;
   logic           rst_n        = 1'b0;
   logic [N-1:0]   req_valid_i  = '0;
   logic [N*8-1:0] req_data_i   = '0;
   logic [N-1:0]   req_last_i   = '0;
   logic [N-1:0]   req_ready_o;
   logic           tx_enable_i  = 1'b1;
   logic           flush_i      = 1'b0;
   logic [7:0]     tx_d_o;
   logic           tx_d_valid_o;
   logic           tx_d_ready_i = 1'b1;
   logic [N-1:0]   grant_o;
   logic           busy_o;
   logic           timeout_o;

   uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid_i),
      .req_data_i   (req_data_i),
      .req_last_i   (req_last_i),
      .req_ready_o  (req_ready_o),
      .tx_enable_i  (tx_enable_i),
      .flush_i      (flush_i),
      .tx_d_o       (tx_d_o),
      .tx_d_valid_o (tx_d_valid_o),
      .tx_d_ready_i (tx_d_ready_i),
      .grant_o      (grant_o),
      .busy_o       (busy_o),
      .timeout_o    (timeout_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [7:0] data;
      logic       last;
   } rec_t;

   typedef struct {
      logic [N-1:0] valid;
      logic         en;
      logic         rdy;
      logic [N-1:0] e_grant;
      logic         e_busy;
      logic         e_txv;
      logic [7:0]   e_txd;
      logic [N-1:0] e_rdy;
   } vec_t;

   rec_t         drv_q[$];
   rec_t         exp_q[$];
   logic [N-1:0] grant_log[$];
   logic [N-1:0] grant_prev = '0;
   int           n_vec  = 0;
   int           n_err  = 0;
   bit           bfm_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_byte(input int id, input logic [7:0] data, input logic last);
      rec_t r;
      r.id   = id;
      r.data = data;
      r.last = last;
      drv_q.push_back(r);
      exp_q.push_back(r);
   endtask

   // bytes[7:0] goes first; the final byte carries last.
   task automatic push_msg(input int id, input int len, input logic [31:0] bytes);
      for (int k = 0; k < len; k++) begin
         push_byte(id, bytes[8*k +: 8], (k == len - 1));
      end
   endtask

   task automatic update_req();
      for (int i = 0; i < N; i++) begin
         int hit;
         hit = -1;
         for (int j = 0; j < drv_q.size(); j++) begin
            if (hit < 0 && drv_q[j].id == i) hit = j;
         end
         if (hit >= 0) begin
            req_valid_i[i]        = 1'b1;
            req_data_i[8*i +: 8]  = drv_q[hit].data;
            req_last_i[i]         = drv_q[hit].last;
         end else begin
            req_valid_i[i]        = 1'b0;
            req_data_i[8*i +: 8]  = 8'h00;
            req_last_i[i]         = 1'b0;
         end
      end
   endtask

   task automatic pop_drv(input int id);
      int hit;
      hit = -1;
      for (int j = 0; j < drv_q.size(); j++) begin
         if (hit < 0 && drv_q[j].id == id) hit = j;
      end
      if (hit >= 0) drv_q.delete(hit);
   endtask

   // Inputs only change at posedge+1, so the negedge sample equals what the edge sees.
   task automatic cycle();
      logic [N-1:0] hs;
      @(negedge clk);
      hs = req_valid_i & req_ready_o;
      @(posedge clk);
      #1;
      if (bfm_en) begin
         for (int i = 0; i < N; i++) begin
            if (hs[i]) pop_drv(i);
         end
         update_req();
      end
   endtask

   task automatic drain(input string name, input int max);
      int k;
      k = 0;
      while ((drv_q.size() != 0 || busy_o) && k < max) begin
         cycle();
         k++;
      end
      n_vec++;
      if (k >= max) begin
         n_err++;
         $display("FAIL %s: not drained after %0d cycles, %0d bytes pending", name, max, drv_q.size());
      end
   endtask

   always @(negedge clk) begin : mon
      int g;
      int hit;
      if (bfm_en) begin
         if (grant_o != '0 && grant_o != grant_prev) grant_log.push_back(grant_o);
         grant_prev = grant_o;
         if (rst_n && tx_d_valid_o && tx_d_ready_i) begin
            g = -1;
            for (int i = 0; i < N; i++) begin
               if (grant_o == N'(1) << i) g = i;
            end
            check("ready_matches_grant", req_ready_o, grant_o);
            hit = -1;
            for (int j = 0; j < exp_q.size(); j++) begin
               if (hit < 0 && exp_q[j].id == g) hit = j;
            end
            if (hit < 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_byte: got 0x%0h with grant 0x%0h, expected no byte", tx_d_o, grant_o);
            end else begin
               check($sformatf("byte_req%0d", g), tx_d_o, exp_q[hit].data);
               exp_q.delete(hit);
            end
         end
      end
   end

   vec_t vt[7];

   initial begin
      vt[0] = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 8'hA0, 4'b0001};
      vt[1] = '{4'b0110, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hA1, 4'b0010};
      vt[2] = '{4'b1100, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1, 8'hA2, 4'b0000};
      vt[3] = '{4'b1000, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b1, 8'hA3, 4'b1000};
      vt[4] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
      vt[5] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
      vt[6] = '{4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hA1, 4'b0010};

      cycle();
      cycle();
      rst_n = 1'b1;
      #1;
      check("rst_grant", grant_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_timeout", timeout_o, 0);
      check("rst_txv", tx_d_valid_o, 0);
      check("rst_ready", req_ready_o, 0);

      // Flush keeps last_grant at its reset value, so every vector searches from 0.
      req_data_i = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      req_last_i = '0;
      for (int v = 0; v < 7; v++) begin
         req_valid_i  = vt[v].valid;
         tx_enable_i  = vt[v].en;
         tx_d_ready_i = vt[v].rdy;
         cycle();
         check($sformatf("v%0d_grant", v), grant_o, vt[v].e_grant);
         check($sformatf("v%0d_busy", v), busy_o, vt[v].e_busy);
         check($sformatf("v%0d_txv", v), tx_d_valid_o, vt[v].e_txv);
         check($sformatf("v%0d_txd", v), tx_d_o, vt[v].e_txd);
         check($sformatf("v%0d_ready", v), req_ready_o, vt[v].e_rdy);
         flush_i = 1'b1;
         #1;
         check($sformatf("v%0d_flush_txv", v), tx_d_valid_o, 0);
         check($sformatf("v%0d_flush_ready", v), req_ready_o, 0);
         cycle();
         flush_i     = 1'b0;
         req_valid_i = '0;
         check($sformatf("v%0d_flush_grant", v), grant_o, 0);
      end
      tx_enable_i  = 1'b1;
      tx_d_ready_i = 1'b1;
      req_data_i   = '0;
      bfm_en       = 1'b1;

      // Single 3-byte message from requester 0.
      push_msg(0, 3, 32'h0033_2211);
      update_req();
      cycle();
      check("t1_grant", grant_o, 4'b0001);
      cycle();
      cycle();
      cycle();
      check("t1_idle_grant", grant_o, 0);
      check("t1_idle_busy", busy_o, 0);
      check("t1_all_bytes", exp_q.size(), 0);

      // Two always-valid requesters alternate from a fresh reset.
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      grant_log.delete();
      push_msg(1, 2, 32'h0000_B2B1);
      push_msg(2, 2, 32'h0000_C2C1);
      push_msg(1, 2, 32'h0000_B4B3);
      push_msg(2, 2, 32'h0000_C4C3);
      update_req();
      drain("t2_drain", 40);
      check("t2_grant_count", grant_log.size(), 4);
      for (int k = 0; k < 4; k++) begin
         logic [N-1:0] act;
         act = (k < grant_log.size()) ? grant_log[k] : '0;
         check($sformatf("t2_order%0d", k), act, (k % 2 == 0) ? 4'b0010 : 4'b0100);
      end

      // FIFO back-pressure for 5 cycles on byte 0xA5.
      push_msg(3, 3, 32'h005B_A55A);
      update_req();
      cycle();
      check("t3_grant", grant_o, 4'b1000);
      cycle();
      tx_d_ready_i = 1'b0;
      #1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("t3_stall%0d_txv", k), tx_d_valid_o, 1);
         check($sformatf("t3_stall%0d_txd", k), tx_d_o, 8'hA5);
         check($sformatf("t3_stall%0d_ready", k), req_ready_o, 0);
         cycle();
      end
      tx_d_ready_i = 1'b1;
      drain("t3_drain", 20);
      check("t3_all_bytes", exp_q.size(), 0);

      // Flush on the cycle the last byte is valid.
      push_msg(1, 2, 32'h0000_6261);
      update_req();
      cycle();
      check("t4_grant", grant_o, 4'b0010);
      cycle();
      flush_i = 1'b1;
      #1;
      check("t4_flush_txv", tx_d_valid_o, 0);
      check("t4_flush_ready", req_ready_o, 0);
      cycle();
      flush_i = 1'b0;
      #1;
      check("t4_post_flush_grant", grant_o, 0);
      check("t4_post_flush_busy", busy_o, 0);
      cycle();
      check("t4_regrant", grant_o, 4'b0010);
      drain("t4_drain", 20);
      check("t4_all_bytes", exp_q.size(), 0);

      // Reset in the middle of a message from requester 2.
      push_msg(2, 3, 32'h0073_7271);
      update_req();
      cycle();
      check("t5_grant", grant_o, 4'b0100);
      cycle();
      rst_n = 1'b0;
      #1;
      check("t5_rst_txv", tx_d_valid_o, 0);
      cycle();
      rst_n = 1'b1;
      drv_q.delete();
      exp_q.delete();
      update_req();
      #1;
      check("t5_rst_grant", grant_o, 0);
      check("t5_rst_busy", busy_o, 0);
      push_msg(0, 1, 32'h0000_0091);
      push_msg(2, 1, 32'h0000_0092);
      update_req();
      cycle();
      check("t5_first_grant", grant_o, 4'b0001);
      drain("t5_drain", 20);
      check("t5_all_bytes", exp_q.size(), 0);

      // Owner goes silent after one byte while requester 2 waits.
      push_byte(1, 8'hD1, 1'b0);
      push_byte(2, 8'hE1, 1'b1);
      update_req();
      cycle();
      check("t6_grant", grant_o, 4'b0010);
      cycle();
`ifdef UART_TX_ARB_TIMEOUT_EN
      for (int k = 0; k < TO - 1; k++) cycle();
      check("t6_held_before_timeout", grant_o, 4'b0010);
      check("t6_no_timeout_yet", timeout_o, 0);
      cycle();
      check("t6_released_grant", grant_o, 0);
      check("t6_timeout_flag", timeout_o, 1);
      cycle();
      check("t6_next_grant", grant_o, 4'b0100);
      drain("t6_drain", 20);
      check("t6_timeout_sticky", timeout_o, 1);
`else
      for (int k = 0; k < 20; k++) cycle();
      check("t6_held_grant", grant_o, 4'b0010);
      check("t6_held_busy", busy_o, 1);
      check("t6_idle_txv", tx_d_valid_o, 0);
      check("t6_idle_txd", tx_d_o, 0);
      check("t6_timeout_tied", timeout_o, 0);
      push_byte(1, 8'hD2, 1'b1);
      update_req();
      drain("t6_drain", 20);
`endif
      check("final_scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
